instr_fetch_unit: RTL

Instruction fetch and decode front end for the multi-cycle MIPS-subset datapath. Owns the program counter, fetches instruction words from instruction memory over a req/ack handshake, and latches them into an instruction register. Presents the decoded opcode and fields to the control state machine, then advances the PC when that machine pulses its PC enable. It is the producer side of the opcode/PC-control interface that the control FSM consumes.

---
 rtl/instr_fetch_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction fetch/decode front end for the
// multi-cycle MIPS-subset datapath.
//
// Optional feature macro: FETCH_TIMEOUT_EN. When defined, a fetch that waits
// TIMEOUT cycles without imem_ack parks the unit in FAULT and raises the
// sticky fetch_fault flag. When undefined, REQ waits indefinitely and
// fetch_fault is tied low.
//
// Fetch handshake: while in REQ, imem_req is held high and imem_addr (= PC)
// is held stable. A transfer happens on a rising edge where imem_req and
// imem_ack are both high. imem_rdata is captured into IR on that edge.
// imem_ack is ignored whenever imem_req is low.
//
// The state is exposed on dbg_state (IDLE=0, REQ=1, HOLD=2, FAULT=3).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_en,
  input  logic [1:0]  pc_sel,
  input  logic        branch_taken,
  input  logic [31:0] reg_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic        tmo_hit;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign dbg_state = state;

  // Field decode straight off IR; fields only move when IR captures a word.
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign imm16  = ir[15:0];
  assign jaddr  = ir[25:0];
  // R-type words carry their operation in funct, so present that instead.
  assign opcode = (ir[31:26] != 6'b000000) ? ir[31:26] : ir[5:0];

  // Next-PC selection; all arithmetic wraps modulo 2^32.
  always_comb begin
    br_off  = {{14{ir[15]}}, ir[15:0], 2'b00};
    next_pc = pc_plus4;
    case (pc_sel)
      2'b00:   next_pc = branch_taken ? (pc_plus4 + br_off) : pc_plus4;
      2'b01:   next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
      2'b10:   next_pc = reg_target;
      default: next_pc = pc;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       fault_q;

  // Fires in the REQ cycle whose missing ack would make the TIMEOUT-th miss.
  assign tmo_hit = ({1'b0, tmo_cnt} + 9'd1) >= TIMEOUT[8:0];

  // Miss counter: cleared on every entry to REQ, counts REQ cycles without ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      if (state == S_IDLE || (state == S_HOLD && pc_en)) begin
        tmo_cnt <= 8'd0;
      end else if (state == S_REQ && !imem_ack) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (state == S_REQ && !imem_ack && tmo_hit) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign fetch_fault = fault_q;
`else
  assign tmo_hit     = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Fetch FSM with registered imem_req / instr_valid; owns PC and IR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      ir          <= 32'd0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          if (imem_ack) begin
            ir          <= imem_rdata;
            state       <= S_HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else if (tmo_hit) begin
            state    <= S_FAULT;
            imem_req <= 1'b0;
          end
        end
        S_HOLD: begin
          if (pc_en) begin
            pc          <= next_pc;
            state       <= S_REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
